fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
Front end of the single-issue core. It holds the PC and fetches each instruction from instruction memory over a req/ack handshake. It decodes the control-flow fields, drives the branch/jump resolver's decode inputs and register-file read addresses, and takes back the resolver's combinational pc_nxt to update the PC. It also forwards every fetched instruction downstream on a valid/ready handshake and raises a sticky error if memory fails to respond.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset.
FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ack before fetch_error (≥1).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
imem_req  out  1  fetch request, held until ack.
imem_addr  out  32  fetch address (= pc).
imem_ack  in  1  memory response valid; honoured only in FETCH.
imem_rdata  in  32  instruction word, sampled with imem_ack.
pc  out  32  current PC, to resolver.
pc_nxt  in  32  next PC from resolver (combinational).
rf_raddr_a  out  5  read addr for branch_rd operand.
rf_raddr_b  out  5  read addr for branch_rs operand.
is_inst_blt, is_inst_bne, is_inst_bex, is_inst_jal, is_inst_jr, is_inst_j  out  1 each  decoded control flags.
branch_offset  out  32  sign-extended ir[16:0].
jump_target  out  27  ir[26:0].
inst_valid  out  1  instruction presented downstream.
inst_ready  in  1  downstream accepts.
inst  out  32  current instruction word (ir).
jal_wb_en  out  1  one-cycle pulse: write r31.
jal_wb_data  out  32  pc + 1 at that pulse.
fetch_error  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset_n=0): state=FETCH, pc=RESET_PC, ir=0, ir_valid=0, timeout counter=0, fetch_error=0, jal_wb_en=0. Every output derived from ir is 0 while ir_valid=0. Reset mid-transaction abandons it; a late imem_ack after release is meaningful only because FETCH re-issues at RESET_PC.
- States: FETCH, DECODE, ISSUE, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc. The counter increments each cycle without ack.
  - On imem_ack: ir<=imem_rdata, ir_valid<=1, counter<=0, go to DECODE.
  - If the counter reaches FETCH_TIMEOUT-1 with no ack: fetch_error<=1, imem_req drops, go to HALT.
- DECODE: a single settle cycle for register-file reads. inst_valid=0.
- ISSUE:
  - inst_valid=1.
  - On inst_valid&inst_ready: pc<=pc_nxt, ir_valid<=0, go to FETCH.
  - If the instruction is jal: jal_wb_en=1 and jal_wb_data=pc+1 in that same handshake cycle only.
  - Until the handshake, pc, ir and all decode outputs hold stable.
- HALT: terminal until reset. imem_req=0, inst_valid=0.
- Decode, gated by ir_valid, opcode=ir[31:27]:
  - j=00001, bne=00010, jal=00011, jr=00100, blt=00110, bex=10110.
  - At most one flag is high. Other opcodes set no flags, so the resolver yields pc+1.
- Operand addresses:
  - rf_raddr_a = 5'd30 when bex, else ir[26:22].
  - rf_raddr_b = ir[21:17].
  - Both are driven during DECODE and ISSUE.
- Arithmetic:
  - branch_offset = {{15{ir[16]}}, ir[16:0]}.
  - jal_wb_data = pc+1, mod 2^32; wraps at 32'hFFFFFFFF→0.
  - pc_nxt is accepted unmodified, including wrap.
- imem_ack outside FETCH is ignored. imem_rdata is sampled only on the ack cycle.
- Minimum instruction period is 3 cycles: ack, decode, issue with ready=1.

Test Plan:
- Reset release with RESET_PC=0 and memory acking next cycle with 32'h0 (non-control) → imem_addr sequence 0,1,2; inst_valid every 3rd cycle; no flags high.
- jal at pc=5 with target 27'd100 → is_inst_jal=1 in ISSUE; on handshake jal_wb_en pulses once with jal_wb_data=6; next imem_addr=100.
- blt at pc=10, rd=r1=3, rs=r2=7, imm=-4 → rf_raddr_a=1, rf_raddr_b=2, branch_offset=32'hFFFFFFFC; next imem_addr=7. Repeat with r1=9 → next imem_addr=11.
- bex at pc=20, target=200 → rf_raddr_a=30. With r30=1, next imem_addr=200; with r30=0, next imem_addr=21.
- Hold inst_ready=0 for 4 cycles in ISSUE → inst_valid stays 1; pc, inst and flags stay constant; the PC updates only on the ready cycle.
- Never ack with FETCH_TIMEOUT=16 → fetch_error=1 after 16 FETCH cycles, imem_req=0 and stays so. Asserting reset_n=0 mid-FETCH immediately clears fetch_error and restores pc=RESET_PC.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// Core front end: PC holder, imem req/ack fetch, control-flow decode and downstream issue.
// Min 3 cycles/instr (ack, decode, issue); ISSUE holds everything stable until inst_ready.
module fetch_decode_unit #(
  parameter logic [31:0] RESET_PC      = 32'd0,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  input  logic [31:0] pc_nxt,
  output logic [4:0]  rf_raddr_a,
  output logic [4:0]  rf_raddr_b,
  output logic        is_inst_blt,
  output logic        is_inst_bne,
  output logic        is_inst_bex,
  output logic        is_inst_jal,
  output logic        is_inst_jr,
  output logic        is_inst_j,
  output logic [31:0] branch_offset,
  output logic [26:0] jump_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        jal_wb_en,
  output logic [31:0] jal_wb_data,
  output logic        fetch_error
);

  localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     ir;
  logic            ir_valid;
  logic [CW-1:0]   cnt;
  logic            handshake;
  logic [4:0]      opcode;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= 32'd0;
      ir_valid    <= 1'b0;
      cnt         <= '0;
      fetch_error <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            cnt      <= '0;
          end else if (cnt == CNT_LAST) begin
            fetch_error <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ISSUE: begin
          if (inst_ready) begin
            pc       <= pc_nxt;
            ir_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)
          state_nxt = S_DECODE;
        else if (cnt == CNT_LAST)
          state_nxt = S_HALT;
      end
      S_DECODE: state_nxt = S_ISSUE;
      S_ISSUE: begin
        inst_valid = 1'b1;
        if (inst_ready)
          state_nxt = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  assign imem_addr = pc;
  assign handshake = inst_valid && inst_ready;
  assign opcode    = ir[31:27];

  // ir_valid is high exactly in DECODE/ISSUE, so it gates every ir-derived output.
  assign is_inst_j   = ir_valid && (opcode == OP_J);
  assign is_inst_bne = ir_valid && (opcode == OP_BNE);
  assign is_inst_jal = ir_valid && (opcode == OP_JAL);
  assign is_inst_jr  = ir_valid && (opcode == OP_JR);
  assign is_inst_blt = ir_valid && (opcode == OP_BLT);
  assign is_inst_bex = ir_valid && (opcode == OP_BEX);

  assign rf_raddr_a    = !ir_valid ? 5'd0 : (is_inst_bex ? 5'd30 : ir[26:22]);
  assign rf_raddr_b    = ir_valid ? ir[21:17] : 5'd0;
  assign branch_offset = ir_valid ? {{15{ir[16]}}, ir[16:0]} : 32'd0;
  assign jump_target   = ir_valid ? ir[26:0] : 27'd0;
  assign inst          = ir_valid ? ir : 32'd0;

  assign jal_wb_en   = handshake && is_inst_jal;
  assign jal_wb_data = jal_wb_en ? (pc + 32'd1) : 32'd0;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboarded bench: program table feeds memory and expected-issue queues; monitors compare.
// Includes a behavioural branch resolver and register file around the front end.
module tb_fetch_decode_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [4:0]  rf_raddr_a;
  logic [4:0]  rf_raddr_b;
  logic        is_inst_blt, is_inst_bne, is_inst_bex, is_inst_jal, is_inst_jr, is_inst_j;
  logic [31:0] branch_offset;
  logic [26:0] jump_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        jal_wb_en;
  logic [31:0] jal_wb_data;
  logic        fetch_error;

  always #5 clock = ~clock;

  fetch_decode_unit #(.RESET_PC(32'd0), .FETCH_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .pc_nxt(pc_nxt), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .is_inst_blt(is_inst_blt), .is_inst_bne(is_inst_bne), .is_inst_bex(is_inst_bex),
    .is_inst_jal(is_inst_jal), .is_inst_jr(is_inst_jr), .is_inst_j(is_inst_j),
    .branch_offset(branch_offset), .jump_target(jump_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .jal_wb_en(jal_wb_en), .jal_wb_data(jal_wb_data), .fetch_error(fetch_error)
  );

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_J    = 6'b000001;
  localparam logic [5:0] F_JR   = 6'b000010;
  localparam logic [5:0] F_JAL  = 6'b000100;
  localparam logic [5:0] F_BEX  = 6'b001000;
  localparam logic [5:0] F_BNE  = 6'b010000;
  localparam logic [5:0] F_BLT  = 6'b100000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  flags;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] off;
    logic [26:0] tgt;
    logic        jwe;
    logic [31:0] jwd;
  } obs_t;

  typedef struct packed {
    logic [4:0]  widx;
    logic [31:0] wval;
    logic        per;
  } aux_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;

  obs_t        exp_q[$];
  aux_t        aux_q[$];
  fetch_t      mem_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf [32];
  logic        spur_en = 1'b0;
  logic [5:0]  flags_now;

  assign flags_now = {is_inst_blt, is_inst_bne, is_inst_bex, is_inst_jal, is_inst_jr, is_inst_j};

  // Branch/jump resolver: taken branches go to pc+1+offset.
  always_comb begin
    pc_nxt = pc + 32'd1;
    if (is_inst_j || is_inst_jal)
      pc_nxt = {5'd0, jump_target};
    else if (is_inst_jr)
      pc_nxt = rf[rf_raddr_a];
    else if (is_inst_bex && rf[rf_raddr_a] != 32'd0)
      pc_nxt = {5'd0, jump_target};
    else if (is_inst_blt && ($signed(rf[rf_raddr_a]) < $signed(rf[rf_raddr_b])))
      pc_nxt = pc + 32'd1 + branch_offset;
    else if (is_inst_bne && rf[rf_raddr_a] != rf[rf_raddr_b])
      pc_nxt = pc + 32'd1 + branch_offset;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] w, input logic [5:0] f,
                     input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] off,
                     input logic [26:0] tgt, input logic jwe, input logic [31:0] jwd,
                     input logic [4:0] widx, input logic [31:0] wval, input logic per);
    obs_t   e;
    aux_t   x;
    fetch_t m;
    m = {a, w};
    e = {a, w, f, ra, rb, off, tgt, jwe, jwd};
    x = {widx, wval, per};
    mem_q.push_back(m);
    exp_q.push_back(e);
    aux_q.push_back(x);
  endtask

  task automatic measure_timeout(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (fetch_error) break;
      if (imem_req) n++;
      @(negedge clock);
    end
  endtask

  // Memory responder: acks the next table entry one cycle after a request.
  initial begin
    fetch_t f;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      if (reset_n && imem_req && mem_q.size() > 0) begin
        f = mem_q.pop_front();
        checks++;
        if (imem_addr !== f.addr) begin
          errors++;
          $display("FAIL fetch_addr got %h want %h", imem_addr, f.addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = f.word;
      end else if (spur_en && !imem_req) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
      end
    end
  end

  // Issue monitor: pops the scoreboard on every handshake, applies register writes.
  initial begin
    obs_t e;
    obs_t o;
    aux_t x;
    int   cyc;
    int   last_hs;
    cyc = 0;
    last_hs = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1]  = 32'd3;
    rf[2]  = 32'd7;
    rf[4]  = 32'hFFFFFFFF;
    rf[30] = 32'd1;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) continue;
      o = {pc, inst, flags_now, rf_raddr_a, rf_raddr_b, branch_offset, jump_target,
           jal_wb_en, jal_wb_data};
      if (inst_valid && inst_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected got %h want none", o);
        end else begin
          e = exp_q.pop_front();
          x = aux_q.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL issue_pc%h got %h want %h", e.pc, o, e);
          end
          if (x.per) begin
            checks++;
            if (cyc - last_hs != 3) begin
              errors++;
              $display("FAIL issue_period got %0d want 3", cyc - last_hs);
            end
          end
          if (x.widx != 5'd0) rf[x.widx] = x.wval;
        end
        last_hs = cyc;
      end else begin
        checks++;
        if (jal_wb_en !== 1'b0 ||
            (imem_req && (inst !== 32'd0 || flags_now !== F_NONE || inst_valid !== 1'b0))) begin
          errors++;
          $display("FAIL idle_outputs got jal=%b inst=%h flags=%b vld=%b want 0", jal_wb_en, inst,
                   flags_now, inst_valid);
        end
      end
    end
  end

  // Backpressure: stall the bne at pc 21 for four ISSUE cycles with stray acks present.
  initial begin
    logic done;
    done = 1'b0;
    inst_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (!done && reset_n && inst_valid && pc == 32'd21) begin
        inst_ready = 1'b0;
        spur_en    = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          chk("stall_valid", 32'(inst_valid), 32'd1);
          chk("stall_pc", pc, 32'd21);
          chk("stall_inst", inst, 32'h10440003);
          chk("stall_flags", 32'(flags_now), 32'(F_BNE));
          @(posedge clock);
          #1;
        end
        inst_ready = 1'b1;
        spur_en    = 1'b0;
        done       = 1'b1;
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #3;
    chk("rst_pc", pc, 32'd0);
    chk("rst_err", 32'(fetch_error), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_jal", 32'(jal_wb_en), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_inst", inst, 32'd0);

    //   addr          word           flags  ra     rb     offset         target          jwe   jwd    wr-reg wr-val per
    add(32'd0,        32'h00000000, F_NONE, 5'd0,  5'd0, 32'd0,        27'd0,          1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd1,        32'h00000000, F_NONE, 5'd0,  5'd0, 32'd0,        27'd0,          1'b0, 32'd0, 5'd0,  32'd0, 1'b1);
    add(32'd2,        32'h00000000, F_NONE, 5'd0,  5'd0, 32'd0,        27'd0,          1'b0, 32'd0, 5'd0,  32'd0, 1'b1);
    add(32'd3,        32'h08000005, F_J,    5'd0,  5'd0, 32'd5,        27'd5,          1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd5,        32'h18000064, F_JAL,  5'd0,  5'd0, 32'd100,      27'd100,        1'b1, 32'd6, 5'd0,  32'd0, 1'b0);
    add(32'd100,      32'h0800000A, F_J,    5'd0,  5'd0, 32'd10,       27'd10,         1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd10,       32'h3045FFFC, F_BLT,  5'd1,  5'd2, 32'hFFFFFFFC, 27'h045FFFC,    1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd7,        32'hF8000000, F_NONE, 5'd0,  5'd0, 32'd0,        27'd0,          1'b0, 32'd0, 5'd1,  32'd9, 1'b0);
    add(32'd8,        32'h0800000A, F_J,    5'd0,  5'd0, 32'd10,       27'd10,         1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd10,       32'h3045FFFC, F_BLT,  5'd1,  5'd2, 32'hFFFFFFFC, 27'h045FFFC,    1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd11,       32'h08000014, F_J,    5'd0,  5'd0, 32'd20,       27'd20,         1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd20,       32'hB00000C8, F_BEX,  5'd30, 5'd0, 32'd200,      27'd200,        1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd200,      32'hF8000000, F_NONE, 5'd0,  5'd0, 32'd0,        27'd0,          1'b0, 32'd0, 5'd30, 32'd0, 1'b0);
    add(32'd201,      32'h08000014, F_J,    5'd0,  5'd0, 32'd20,       27'd20,         1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd20,       32'hB00000C8, F_BEX,  5'd30, 5'd0, 32'd200,      27'd200,        1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd21,       32'h10440003, F_BNE,  5'd1,  5'd2, 32'd3,        27'h0440003,    1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'd25,       32'h21000000, F_JR,   5'd4,  5'd0, 32'd0,        27'h1000000,    1'b0, 32'd0, 5'd0,  32'd0, 1'b0);
    add(32'hFFFFFFFF, 32'h18000040, F_JAL,  5'd0,  5'd0, 32'h40,       27'h40,         1'b1, 32'd0, 5'd0,  32'd0, 1'b0);

    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clock);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    chk("final_addr", imem_addr, 32'h40);

    // Memory goes silent: fetch at 0x40 must time out.
    measure_timeout(n);
    chk("timeout_cycles", 32'(n), 32'd16);
    chk("halt_err", 32'(fetch_error), 32'd1);
    repeat (5) @(negedge clock);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_err_sticky", 32'(fetch_error), 32'd1);
    chk("halt_valid", 32'(inst_valid), 32'd0);
    chk("mem_left", 32'(mem_q.size()), 32'd0);

    reset_n = 1'b0;
    #1;
    chk("rst2_err", 32'(fetch_error), 32'd0);
    chk("rst2_pc", pc, 32'd0);
    chk("rst2_req", 32'(imem_req), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    measure_timeout(n);
    chk("timeout2_cycles", 32'(n), 32'd16);

    // Reset partway through a fetch must also clear the timeout counter.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midfetch_err", 32'(fetch_error), 32'd0);
    chk("midfetch_pc", pc, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    measure_timeout(n);
    chk("timeout3_cycles", 32'(n), 32'd16);
    chk("timeout3_err", 32'(fetch_error), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
